// File: rtl/prog_seq_pkg.sv
// Shared types for the program sequencer: FSM state encoding and the
// width of the program-select field.
package prog_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_RUN,
      S_DONE,
      S_FINISH
   } state_e;

   localparam int PROG_SEL_W = 2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Supervisor that launches NUM_PROGS programs on the core back to back,
// holding init, waiting for halt, and recording each program's run length.
module prog_sequencer
   import prog_seq_pkg::*;
#(
   parameter int NUM_PROGS   = 3,
   parameter int INIT_CYCLES = 1,
   parameter int CNT_W       = 16,
   parameter int MAX_CYCLES  = 50000
) (
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic                  start,
   input  logic                  halt,
   output logic                  init,
   output logic [PROG_SEL_W-1:0] prog_sel,
   output logic                  busy,
   output logic                  prog_done,
   output logic [CNT_W-1:0]      cycle_count,
   output logic                  timeout,
   output logic                  all_done
);

   localparam int                    INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0]     INIT_LOAD = INIT_W'(INIT_CYCLES - 1);
   localparam logic [PROG_SEL_W-1:0] LAST_SEL  = PROG_SEL_W'(NUM_PROGS - 1);

   state_e                  state_q, state_d;
   logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
   logic [PROG_SEL_W-1:0]   prog_sel_q, prog_sel_d;
   logic                    timeout_q, timeout_d;
   logic                    all_done_q, all_done_d;
   logic [CNT_W-1:0]        cycle_count_q, cycle_count_d;
   logic                    init_q, busy_q, prog_done_q;
   logic [CNT_W-1:0]        run_cnt;
   logic                    run_clr, run_en, limit_hit;

   // The counter is held clear throughout INIT so RUN always starts at zero.
   sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
      .clk_i   (CLK),
      .rst_ni  (RSTn),
      .clr_i   (run_clr),
      .en_i    (run_en),
      .count_o (run_cnt)
   );

   // True on the RUN cycle whose increment would bring the count to MAX_CYCLES.
   assign limit_hit = (32'(run_cnt) >= 32'(MAX_CYCLES - 1));

   always_comb begin
      state_d       = state_q;
      init_cnt_d    = init_cnt_q;
      prog_sel_d    = prog_sel_q;
      timeout_d     = timeout_q;
      all_done_d    = all_done_q;
      cycle_count_d = cycle_count_q;
      run_clr       = 1'b0;
      run_en        = 1'b0;
      case (state_q)
         S_IDLE, S_FINISH: begin
            if (start) begin
               state_d       = S_INIT;
               init_cnt_d    = INIT_LOAD;
               prog_sel_d    = '0;
               timeout_d     = 1'b0;
               all_done_d    = 1'b0;
               cycle_count_d = '0;
            end
         end
         S_INIT: begin
            run_clr = 1'b1;
            if (init_cnt_q == '0) begin
               state_d = S_RUN;
            end else begin
               init_cnt_d = init_cnt_q - INIT_W'(1);
            end
         end
         S_RUN: begin
            if (halt) begin
               state_d = S_DONE;
            end else begin
               run_en = 1'b1;
               if (limit_hit) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            cycle_count_d = run_cnt;
            if (prog_sel_q == LAST_SEL) begin
               state_d    = S_FINISH;
               all_done_d = 1'b1;
            end else begin
               state_d    = S_INIT;
               init_cnt_d = INIT_LOAD;
               prog_sel_d = prog_sel_q + PROG_SEL_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q       <= S_IDLE;
         init_cnt_q    <= '0;
         prog_sel_q    <= '0;
         timeout_q     <= 1'b0;
         all_done_q    <= 1'b0;
         cycle_count_q <= '0;
         init_q        <= 1'b0;
         busy_q        <= 1'b0;
         prog_done_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         init_cnt_q    <= init_cnt_d;
         prog_sel_q    <= prog_sel_d;
         timeout_q     <= timeout_d;
         all_done_q    <= all_done_d;
         cycle_count_q <= cycle_count_d;
         init_q        <= (state_d == S_INIT);
         busy_q        <= (state_d == S_INIT) || (state_d == S_RUN);
         prog_done_q   <= (state_d == S_DONE);
      end
   end

   assign init        = init_q;
   assign prog_sel    = prog_sel_q;
   assign busy        = busy_q;
   assign prog_done   = prog_done_q;
   assign cycle_count = cycle_count_q;
   assign timeout     = timeout_q;
   assign all_done    = all_done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: two instances (short watchdog, and narrow counter)
// driven from a vector table, hand sequences and random program lengths.
module tb_prog_sequencer;

   localparam int A_I = 2, A_MAX = 20,    A_W = 16;
   localparam int B_I = 1, B_MAX = 50000, B_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn_a, start_a, halt_a, init_a, busy_a, pd_a, to_a, all_a;
   logic [1:0]  sel_a;
   logic [15:0] cc_a;
   logic        rstn_b, start_b, halt_b, init_b, busy_b, pd_b, to_b, all_b;
   logic [1:0]  sel_b;
   logic [3:0]  cc_b;

   prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(A_I), .CNT_W(A_W), .MAX_CYCLES(A_MAX)) dut_a (
      .CLK(clk), .RSTn(rstn_a), .start(start_a), .halt(halt_a), .init(init_a),
      .prog_sel(sel_a), .busy(busy_a), .prog_done(pd_a), .cycle_count(cc_a),
      .timeout(to_a), .all_done(all_a));

   prog_sequencer #(.NUM_PROGS(3), .INIT_CYCLES(B_I), .CNT_W(B_W), .MAX_CYCLES(B_MAX)) dut_b (
      .CLK(clk), .RSTn(rstn_b), .start(start_b), .halt(halt_b), .init(init_b),
      .prog_sel(sel_b), .busy(busy_b), .prog_done(pd_b), .cycle_count(cc_b),
      .timeout(to_b), .all_done(all_b));

   int checks = 0;
   int errors = 0;
   int obs_cc[3];
   logic obs_to;
   int obs_gap;

   typedef struct {
      logic init; int sel; logic busy; logic pd; logic all; logic to; int cc; int halt;
   } cyc_t;

   typedef struct {
      int which; int d0; int d1; int d2; int fill; logic noise;
      int c0; int c1; int c2; logic to; int gap;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input int which, input logic st, input logic h);
      if (which == 0) begin
         start_a = st; halt_a = h;
      end else begin
         start_b = st; halt_b = h;
      end
   endtask

   function automatic logic [22:0] sample(input int which);
      return (which == 0) ? {init_a, sel_a, busy_a, pd_a, all_a, to_a, cc_a}
                          : {init_b, sel_b, busy_b, pd_b, all_b, to_b, 12'd0, cc_b};
   endfunction

   function automatic logic [22:0] pack_exp(input cyc_t e);
      return {e.init, e.sel[1:0], e.busy, e.pd, e.all, e.to, e.cc[15:0]};
   endfunction

   // h: 0/1 forced value during RUN; 2 means "don't care" -> use fill policy
   function automatic logic halt_val(input int h, input int fill);
      if (h < 2) return h[0];
      if (fill < 2) return fill[0];
      return logic'($urandom_range(0, 1));
   endfunction

   // Reference model: expand the three program lengths into the expected
   // per-cycle output trace, then drive and compare cycle by cycle.
   task automatic run_seq(input int which, input int d0, input int d1, input int d2,
                          input int fill, input logic noise);
      cyc_t q[$];
      cyc_t e;
      int ds[3];
      int ni, mx, satmax, len, cnt, cc, npd, pd_at0;
      logic to, tf, prev_pd;
      logic [22:0] act, exp_v;
      ds     = '{d0, d1, d2};
      ni     = (which == 0) ? A_I : B_I;
      mx     = (which == 0) ? A_MAX : B_MAX;
      satmax = (which == 0) ? ((1 << A_W) - 1) : ((1 << B_W) - 1);
      to = 1'b0;
      cc = 0;
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < ni; k++) begin
            e = '{init:1'b1, sel:p, busy:1'b1, pd:1'b0, all:1'b0, to:to, cc:cc, halt:2};
            q.push_back(e);
         end
         tf  = (ds[p] >= mx);
         len = tf ? mx : ds[p] + 1;
         cnt = tf ? mx : ds[p];
         if (cnt > satmax) cnt = satmax;
         for (int r = 0; r < len; r++) begin
            e = '{init:1'b0, sel:p, busy:1'b1, pd:1'b0, all:1'b0, to:to, cc:cc,
                  halt:((!tf && r == ds[p]) ? 1 : 0)};
            q.push_back(e);
         end
         if (tf) to = 1'b1;
         e = '{init:1'b0, sel:p, busy:1'b0, pd:1'b1, all:1'b0, to:to, cc:cc, halt:2};
         q.push_back(e);
         cc = cnt;
      end
      for (int k = 0; k < 2; k++) begin
         e = '{init:1'b0, sel:2, busy:1'b0, pd:1'b0, all:1'b1, to:to, cc:cc, halt:2};
         q.push_back(e);
      end

      obs_cc  = '{-1, -1, -1};
      obs_gap = -1;
      obs_to  = 1'b0;
      npd     = 0;
      pd_at0  = 0;
      prev_pd = 1'b0;
      @(negedge clk);
      drive(which, 1'b1, halt_val(2, fill));
      foreach (q[i]) begin
         @(negedge clk);
         act   = sample(which);
         exp_v = pack_exp(q[i]);
         checks++;
         if (act !== exp_v) begin
            errors++;
            $display("FAIL trace dut%0d cyc%0d: got init/sel/busy/done/all/to/cnt=%0b/%0d/%0b/%0b/%0b/%0b/%0d want %0b/%0d/%0b/%0b/%0b/%0b/%0d",
                     which, i, act[22], act[21:20], act[19], act[18], act[17], act[16], act[15:0],
                     exp_v[22], exp_v[21:20], exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
         end
         if (prev_pd && npd >= 1) obs_cc[npd-1] = int'(act[15:0]);
         if (act[18]) begin
            if (npd == 0) pd_at0 = i;
            else if (npd == 1) obs_gap = i - pd_at0;
            if (npd < 3) npd++;
         end
         prev_pd = act[18];
         obs_to  = act[16];
         drive(which, noise && (q[i].busy || q[i].pd) && ($urandom_range(0, 2) == 0),
               halt_val(q[i].halt, fill));
      end
      drive(which, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = '{which:0, d0:10,  d1:10, d2:10, fill:0, noise:1'b0, c0:10, c1:10, c2:10, to:1'b0, gap:0};
      tbl[1] = '{which:0, d0:0,   d1:0,  d2:0,  fill:1, noise:1'b0, c0:0,  c1:0,  c2:0,  to:1'b0, gap:A_I+2};
      tbl[2] = '{which:0, d0:100, d1:5,  d2:19, fill:0, noise:1'b1, c0:20, c1:5,  c2:19, to:1'b1, gap:0};
      tbl[3] = '{which:0, d0:4,   d1:6,  d2:8,  fill:2, noise:1'b1, c0:4,  c1:6,  c2:8,  to:1'b0, gap:0};
      tbl[4] = '{which:0, d0:3,   d1:20, d2:1,  fill:0, noise:1'b0, c0:3,  c1:20, c2:1,  to:1'b1, gap:0};
      tbl[5] = '{which:1, d0:30,  d1:2,  d2:15, fill:0, noise:1'b0, c0:15, c1:2,  c2:15, to:1'b0, gap:0};
      tbl[6] = '{which:1, d0:14,  d1:16, d2:0,  fill:2, noise:1'b1, c0:14, c1:15, c2:0,  to:1'b0, gap:0};
      tbl[7] = '{which:1, d0:0,   d1:0,  d2:0,  fill:1, noise:1'b0, c0:0,  c1:0,  c2:0,  to:1'b0, gap:B_I+2};

      rstn_a = 1'b0; start_a = 1'b0; halt_a = 1'b0;
      rstn_b = 1'b0; start_b = 1'b0; halt_b = 1'b0;
      #1;
      chk("reset_a", 32'(sample(0)), 0);
      chk("reset_b", 32'(sample(1)), 0);
      repeat (3) @(negedge clk);
      chk("reset_hold_a", 32'(sample(0)), 0);
      rstn_a = 1'b1;
      rstn_b = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_seq(tbl[i].which, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].fill, tbl[i].noise);
         chk($sformatf("vec%0d_cnt0", i), obs_cc[0], tbl[i].c0);
         chk($sformatf("vec%0d_cnt1", i), obs_cc[1], tbl[i].c1);
         chk($sformatf("vec%0d_cnt2", i), obs_cc[2], tbl[i].c2);
         chk($sformatf("vec%0d_timeout", i), 32'(obs_to), 32'(tbl[i].to));
         if (tbl[i].gap != 0) chk($sformatf("vec%0d_done_gap", i), obs_gap, tbl[i].gap);
      end

      // Asynchronous reset in the middle of program 1's RUN phase.
      @(negedge clk); drive(0, 1'b1, 1'b0);
      @(negedge clk); drive(0, 1'b0, 1'b0);
      n = 0;
      while (!(sel_a == 2'd1 && busy_a && !init_a) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_prog1_run", 32'(n < 200), 1);
      repeat (3) @(negedge clk);
      #2 rstn_a = 1'b0;
      #1 chk("async_reset_mid_run", 32'(sample(0)), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("reset_no_done", 32'({pd_a, busy_a, init_a}), 0);
      end
      rstn_a = 1'b1;
      run_seq(0, 2, 3, 4, 0, 1'b0);
      chk("after_reset_cnt0", obs_cc[0], 2);
      chk("after_reset_cnt2", obs_cc[2], 4);

      for (int r = 0; r < 8; r++) begin
         int w, lim;
         w   = r % 2;
         lim = (w == 0) ? 25 : 40;
         run_seq(w, $urandom_range(0, lim), $urandom_range(0, lim), $urandom_range(0, lim),
                 $urandom_range(0, 2), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
